// File: rtl/cdb_unit.sv
// cdb_unit: Common Data Bus arbiter for the 2-way R10K core.
// Up to CDB_W of NUM_FU completed functional-unit results win a broadcast
// lane each cycle; losers see a same-cycle stall and retry next cycle.
// Grant and stall are combinational; the lane broadcast is registered, so
// a grant appears on the bus exactly one cycle later.
// Optional feature macro: CDB_ROUND_ROBIN_EN (rotating priority pointer).
// Without it, FU0 has the highest priority and FU(NUM_FU-1) the lowest.
module cdb_unit #(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 2,
    parameter int PREG_W = 6,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_FU-1:0]          fub_valid,
    input  logic [NUM_FU*PREG_W-1:0]   fub_tagDest,
    input  logic [NUM_FU*DATA_W-1:0]   fub_result,
    output logic [CDB_W*PREG_W-1:0]    cdb_rd,
    output logic [CDB_W-1:0]           cdb_rd_en,
    output logic [CDB_W*DATA_W-1:0]    cdb_reg_value,
    output logic [NUM_FU-1:0]          cdb_stall
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    // Per-FU views of the flattened input buses.
    logic [PREG_W-1:0]   fu_tag [NUM_FU];
    logic [DATA_W-1:0]   fu_res [NUM_FU];

    // Grant bookkeeping and next-state values for the broadcast registers.
    logic [NUM_FU-1:0]        granted;
    logic [PTR_W:0]           scan_sum;
    logic [PTR_W-1:0]         scan_idx;
    logic                     take;
    logic [PTR_W-1:0]         prio_base;

    logic [CDB_W-1:0]         cdb_rd_en_d,     cdb_rd_en_q;
    logic [CDB_W*PREG_W-1:0]  cdb_rd_d,        cdb_rd_q;
    logic [CDB_W*DATA_W-1:0]  cdb_reg_value_d, cdb_reg_value_q;

`ifdef CDB_ROUND_ROBIN_EN
    logic [PTR_W-1:0]         ptr_d, ptr_q;
    logic [PTR_W-1:0]         last_fu;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_FU; gi++) begin : g_unpack
            assign fu_tag[gi] = fub_tagDest[gi*PREG_W +: PREG_W];
            assign fu_res[gi] = fub_result[gi*DATA_W +: DATA_W];
        end
    endgenerate

`ifdef CDB_ROUND_ROBIN_EN
    assign prio_base = ptr_q;
`else
    assign prio_base = '0;
`endif

    // Scan FUs from the priority base; each valid FU takes the lowest free lane.
    always_comb begin
        granted         = '0;
        cdb_rd_en_d     = '0;
        cdb_rd_d        = '0;
        cdb_reg_value_d = '0;
        scan_sum        = '0;
        scan_idx        = '0;
        take            = 1'b0;
`ifdef CDB_ROUND_ROBIN_EN
        last_fu         = '0;
`endif
        for (int j = 0; j < NUM_FU; j++) begin
            // Wrap (base + j) into 0..NUM_FU-1; both terms are below NUM_FU.
            scan_sum = {1'b0, prio_base} + (PTR_W+1)'(j);
            if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            take     = fub_valid[scan_idx];
            for (int k = 0; k < CDB_W; k++) begin
                if (take && !cdb_rd_en_d[k]) begin
                    cdb_rd_en_d[k]                      = 1'b1;
                    cdb_rd_d[k*PREG_W +: PREG_W]        = fu_tag[scan_idx];
                    cdb_reg_value_d[k*DATA_W +: DATA_W] = fu_res[scan_idx];
                    granted[scan_idx]                   = 1'b1;
`ifdef CDB_ROUND_ROBIN_EN
                    last_fu                             = scan_idx;
`endif
                    take                                = 1'b0;
                end
            end
        end
    end

`ifdef CDB_ROUND_ROBIN_EN
    // Next priority starts just past the last FU granted; hold when idle.
    always_comb begin
        ptr_d = ptr_q;
        if (|cdb_rd_en_d) begin
            ptr_d = (last_fu == PTR_W'(NUM_FU-1)) ? '0 : last_fu + PTR_W'(1);
        end
    end
`endif

    // Losers must hold their result; idle FUs are never stalled.
    assign cdb_stall = fub_valid & ~granted;

    // Broadcast registers; reset discards any in-flight broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_rd_en_q     <= '0;
            cdb_rd_q        <= '0;
            cdb_reg_value_q <= '0;
`ifdef CDB_ROUND_ROBIN_EN
            ptr_q           <= '0;
`endif
        end else begin
            cdb_rd_en_q     <= cdb_rd_en_d;
            cdb_rd_q        <= cdb_rd_d;
            cdb_reg_value_q <= cdb_reg_value_d;
`ifdef CDB_ROUND_ROBIN_EN
            ptr_q           <= ptr_d;
`endif
        end
    end

    assign cdb_rd_en     = cdb_rd_en_q;
    assign cdb_rd        = cdb_rd_q;
    assign cdb_reg_value = cdb_reg_value_q;

endmodule

// File: tb/tb_cdb_unit.sv
// tb_cdb_unit: self-checking bench for cdb_unit.
// A queue-based model picks the first two valid FUs in priority order and
// predicts stall (same cycle) and the lane broadcast (next cycle); a compare
// process checks it on every falling edge. Directed literal checks pin the
// model; a random phase obeys the hold-while-stalled protocol.
module tb_cdb_unit;

    localparam int NFU = 8;
    localparam int NL  = 2;
    localparam int TW  = 6;
    localparam int DW  = 64;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NFU-1:0]    valid;
    logic [TW-1:0]     tag [NFU];
    logic [DW-1:0]     res [NFU];
    logic [NFU*TW-1:0] tag_flat;
    logic [NFU*DW-1:0] res_flat;

    logic [NL*TW-1:0]  cdb_rd;
    logic [NL-1:0]     cdb_rd_en;
    logic [NL*DW-1:0]  cdb_reg_value;
    logic [NFU-1:0]    cdb_stall;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model state
    int             m_base = 0;
    logic           pend_en  [NL];
    logic [TW-1:0]  pend_tag [NL];
    logic [DW-1:0]  pend_val [NL];
    logic [NFU-1:0] model_stall = '0;

    cdb_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fub_valid     (valid),
        .fub_tagDest   (tag_flat),
        .fub_result    (res_flat),
        .cdb_rd        (cdb_rd),
        .cdb_rd_en     (cdb_rd_en),
        .cdb_reg_value (cdb_reg_value),
        .cdb_stall     (cdb_stall)
    );

    always #5 clk = ~clk;

    always_comb begin
        tag_flat = '0;
        res_flat = '0;
        for (int i = 0; i < NFU; i++) begin
            tag_flat[i*TW +: TW] = tag[i];
            res_flat[i*DW +: DW] = res[i];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare process: registered lanes vs last prediction, stall vs now.
    always @(negedge clk) begin
        int q[$];
        int nw;
        logic [NFU-1:0] exp_stall;
        cyc++;
        if (!rst_n) begin
            m_base = 0;
            for (int k = 0; k < NL; k++) begin
                pend_en[k] = 1'b0; pend_tag[k] = '0; pend_val[k] = '0;
            end
        end
        for (int k = 0; k < NL; k++) begin
            chk($sformatf("m_en%0d", k),  cdb_rd_en[k],              pend_en[k]);
            chk($sformatf("m_rd%0d", k),  cdb_rd[k*TW +: TW],         pend_tag[k]);
            chk($sformatf("m_val%0d", k), cdb_reg_value[k*DW +: DW],  pend_val[k]);
        end
        q = {};
        for (int j = 0; j < NFU; j++) begin
            if (valid[(m_base + j) % NFU]) q.push_back((m_base + j) % NFU);
        end
        nw = (q.size() > NL) ? NL : q.size();
        exp_stall = valid;
        for (int w = 0; w < nw; w++) exp_stall[q[w]] = 1'b0;
        chk("m_stall", cdb_stall, exp_stall);
        model_stall = exp_stall;
        if (rst_n) begin
            for (int k = 0; k < NL; k++) begin
                pend_en[k]  = (k < nw);
                pend_tag[k] = (k < nw) ? tag[q[k]] : '0;
                pend_val[k] = (k < nw) ? res[q[k]] : '0;
            end
`ifdef CDB_ROUND_ROBIN_EN
            if (nw > 0) m_base = (q[nw-1] + 1) % NFU;
`endif
        end
        $display("cyc %0d rst_n=%b valid=%h stall=%h en=%b rd=%h", cyc, rst_n, valid,
                 cdb_stall, cdb_rd_en, cdb_rd);
    end

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        @(posedge clk); #2;
        valid = '0;
        rst_n = 1'b1;
    endtask

    logic [NFU-1:0] st_tab [4];
    int             l0_tab [4];

    initial begin
        valid = '0;
        for (int i = 0; i < NFU; i++) begin
            tag[i] = '0; res[i] = '0;
        end
        #1 rst_n = 1'b0;

        // 1: reset with all FUs valid, then first broadcast after release
        for (int i = 0; i < NFU; i++) begin
            tag[i] = 6'(i + 1); res[i] = 64'(100 + i);
        end
        valid = 8'hFF;
        @(posedge clk); #1;
        chk("rst_en", cdb_rd_en, 2'b00);
        chk("rst_rd", cdb_rd, 12'h000);
        chk("rst_val", cdb_reg_value[63:0], 64'h0);
        chk("rst_stall", cdb_stall, 8'hFC);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_en", cdb_rd_en, 2'b11);
        chk("rel_rd0", cdb_rd[5:0], 6'd1);
        chk("rel_rd1", cdb_rd[11:6], 6'd2);
        chk("rel_val1", cdb_reg_value[127:64], 64'd101);

        // 2: single valid FU goes to lane 0 only
        do_reset();
        @(posedge clk); #2;
        valid = 8'b0000_0100; tag[2] = 6'd5; res[2] = 64'hAB;
        #1 chk("t2_stall", cdb_stall, 8'h00);
        @(posedge clk); #1;
        chk("t2_en", cdb_rd_en, 2'b01);
        chk("t2_rd0", cdb_rd[5:0], 6'd5);
        chk("t2_val0", cdb_reg_value[63:0], 64'hAB);
        chk("t2_rd1", cdb_rd[11:6], 6'd0);

        // 3: three valid FUs -> FU1, FU4 win, FU7 stalled
        do_reset();
        @(posedge clk); #2;
        tag[1] = 6'd11; tag[4] = 6'd14; tag[7] = 6'd17;
        res[1] = 64'h1111; res[4] = 64'h4444; res[7] = 64'h7777;
        valid = 8'b1001_0010;
        #1 chk("t3_stall", cdb_stall, 8'b1000_0000);
        @(posedge clk); #1;
        chk("t3_rd0", cdb_rd[5:0], 6'd11);
        chk("t3_rd1", cdb_rd[11:6], 6'd14);
        chk("t3_val1", cdb_reg_value[127:64], 64'h4444);
        // reset mid-broadcast discards the lanes immediately
        #1 rst_n = 1'b0;
        #1 chk("midrst_en", cdb_rd_en, 2'b00);
        chk("midrst_val", cdb_reg_value[63:0], 64'h0);
        @(posedge clk); #2;
        valid = '0;
        rst_n = 1'b1;

        // 4/5: all FUs valid for four cycles
`ifdef CDB_ROUND_ROBIN_EN
        st_tab = '{8'hFC, 8'hF3, 8'hCF, 8'h3F};
        l0_tab = '{1, 3, 5, 7};
`else
        st_tab = '{8'hFC, 8'hFC, 8'hFC, 8'hFC};
        l0_tab = '{1, 1, 1, 1};
`endif
        do_reset();
        for (int i = 0; i < NFU; i++) begin
            tag[i] = 6'(i + 1); res[i] = 64'(100 + i);
        end
        @(posedge clk); #2;
        valid = 8'hFF;
        for (int c = 0; c < 4; c++) begin
            #1 chk($sformatf("t4_stall%0d", c), cdb_stall, st_tab[c]);
            @(posedge clk); #1;
            chk($sformatf("t4_rd0_%0d", c), cdb_rd[5:0], 6'(l0_tab[c]));
            chk($sformatf("t4_rd1_%0d", c), cdb_rd[11:6], 6'(l0_tab[c] + 1));
            #1;
        end

        // 6: random stress; stalled FUs hold their valid/tag/result
        for (int n = 0; n < 255; n++) begin
            @(posedge clk); #2;
            for (int i = 0; i < NFU; i++) begin
                if (!model_stall[i]) begin
                    valid[i] = ($urandom_range(0, 99) < 55);
                    tag[i]   = 6'($urandom);
                    res[i]   = {$urandom, $urandom};
                end
            end
        end

        @(posedge clk); #2;
        valid = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
